// File: rtl/dem_pkg.sv
// Shared types, constants and helpers for the tree-structured DEM encoder.
package dem_pkg;

  localparam int unsigned DEM_WIDTH = 5;
  localparam int unsigned CLIP_W    = 16;

  typedef logic signed [1:0] sw_t;

  localparam sw_t SW_POS  = 2'sd1;
  localparam sw_t SW_ZERO = 2'sd0;
  localparam sw_t SW_NEG  = -2'sd1;

  // Generous fixed width so any node width up to CLIP_W can share it without overflow of 2*cap.
  function automatic logic [CLIP_W:0] clip_count(input logic [CLIP_W-1:0] x,
                                                 input logic [CLIP_W-1:0] cap);
    logic [CLIP_W:0] cap2;
    logic [CLIP_W:0] xw;
    cap2 = {cap, 1'b0};
    xw   = {1'b0, x};
    return (xw > cap2) ? cap2 : xw;
  endfunction

endpackage

// File: rtl/dem_split_calc.sv
// Combinational split of an effective count into two child counts using switching value s.
module dem_split_calc
  import dem_pkg::*;
#(
  parameter int unsigned WIDTH = DEM_WIDTH
) (
  input  logic [WIDTH:0]   x_eff,
  input  sw_t              s,
  output logic [WIDTH-1:0] x1,
  output logic [WIDTH-1:0] x2
);

  logic signed [WIDTH+1:0] xe_s;
  logic signed [WIDTH+1:0] s_ext;
  logic signed [WIDTH+1:0] sum;
  logic signed [WIDTH+1:0] dif;

  // s is only nonzero for odd x_eff, so both sums stay non-negative and even.
  always_comb begin
    xe_s  = signed'({1'b0, x_eff});
    s_ext = (WIDTH+2)'(s);
    sum   = xe_s + s_ext;
    dif   = xe_s - s_ext;
    x1    = WIDTH'(sum >>> 1);
    x2    = WIDTH'(dif >>> 1);
  end

endmodule

// File: rtl/dem_switching_block.sv
// One DEM tree node: clips the request, picks s from parity and shaping state, registers the split.
// Optional first-order noise shaping of the sign is enabled by defining SWB_NOISE_SHAPE_EN.
module dem_switching_block
  import dem_pkg::*;
#(
  parameter int unsigned WIDTH = DEM_WIDTH
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] x_in_i,
  input  logic             pn_seq_i,
  input  logic [WIDTH-1:0] quantized_value_i,
  output logic [WIDTH-1:0] x_out1_o,
  output logic [WIDTH-1:0] x_out2_o,
  output logic [WIDTH-1:0] s_out_o
);

  logic [WIDTH:0]   x_eff;
  sw_t              s_next;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;

`ifdef SWB_NOISE_SHAPE_EN
  sw_t acc;
`endif

  always_comb begin
    x_eff = (WIDTH+1)'(clip_count(CLIP_W'(x_in_i), CLIP_W'(quantized_value_i)));
  end

  always_comb begin
    s_next = SW_ZERO;
    if (x_eff[0]) begin
`ifdef SWB_NOISE_SHAPE_EN
      // Drive the accumulated imbalance back toward zero; PN breaks the tie.
      case (acc)
        SW_ZERO: s_next = pn_seq_i ? SW_POS : SW_NEG;
        SW_POS:  s_next = SW_NEG;
        default: s_next = SW_POS;
      endcase
`else
      s_next = pn_seq_i ? SW_POS : SW_NEG;
`endif
    end
  end

  dem_split_calc #(
    .WIDTH(WIDTH)
  ) u_split (
    .x_eff(x_eff),
    .s    (s_next),
    .x1   (x1),
    .x2   (x2)
  );

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      x_out1_o <= '0;
      x_out2_o <= '0;
      s_out_o  <= '0;
`ifdef SWB_NOISE_SHAPE_EN
      acc      <= SW_ZERO;
`endif
    end else begin
      x_out1_o <= x1;
      x_out2_o <= x2;
      s_out_o  <= WIDTH'(s_next);
`ifdef SWB_NOISE_SHAPE_EN
      acc      <= acc + s_next;
`endif
    end
  end

endmodule

// File: tb/tb_dem_switching_block.sv
// Directed self-checking bench for dem_switching_block; expectations follow SWB_NOISE_SHAPE_EN when defined.
module tb_dem_switching_block;

  logic       clk_i;
  logic       reset_i;
  logic [4:0] x_in_i;
  logic       pn_seq_i;
  logic [4:0] quantized_value_i;
  logic [4:0] x_out1_o;
  logic [4:0] x_out2_o;
  logic [4:0] s_out_o;

  int checks = 0;
  int errors = 0;

  dem_switching_block #(
    .WIDTH(5)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .x_in_i           (x_in_i),
    .pn_seq_i         (pn_seq_i),
    .quantized_value_i(quantized_value_i),
    .x_out1_o         (x_out1_o),
    .x_out2_o         (x_out2_o),
    .s_out_o          (s_out_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic cmp(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] e1, input logic [4:0] e2,
                     input logic [4:0] es);
    cmp({tag, ".x1"}, x_out1_o, e1);
    cmp({tag, ".x2"}, x_out2_o, e2);
    cmp({tag, ".s"}, s_out_o, es);
  endtask

  // Apply one sample, then look at the registered result 1 time unit after the edge.
  task automatic step(input logic [4:0] cap, input logic [4:0] x, input logic pn);
    quantized_value_i = cap;
    x_in_i            = x;
    pn_seq_i          = pn;
    @(posedge clk_i);
    #1;
  endtask

  localparam logic [4:0] NEG1 = 5'b11111;

  // Eight x=1 samples, index 0 first.
  logic [7:0] pn_pat = 8'b1100_1011;  // bits 0..7: 1,1,0,1,0,0,1,1
`ifdef SWB_NOISE_SHAPE_EN
  logic [7:0] s_pos_exp = 8'b0110_1001; // + - - + - + + -
`else
  logic [7:0] s_pos_exp = 8'b1100_1011; // s tracks pn directly
`endif

  initial begin
    int run_sum;
    reset_i = 1'b1;
    x_in_i = '0;
    pn_seq_i = 1'b0;
    quantized_value_i = '0;
    #2 reset_i = 1'b0;
    #1 chk("reset_async", 5'd0, 5'd0, 5'd0);
    @(posedge clk_i);
    #1 chk("reset_held", 5'd0, 5'd0, 5'd0);
    reset_i = 1'b1;

    // Odd samples starting from acc=0.
    step(5'd3, 5'd3, 1'b1); chk("odd_c3x3_pn1", 5'd2, 5'd1, 5'd1);
    step(5'd5, 5'd5, 1'b0); chk("odd_c5x5_pn0", 5'd2, 5'd3, NEG1);
    step(5'd3, 5'd3, 1'b1); chk("odd_third_pn1", 5'd2, 5'd1, 5'd1);

    // Even and clipped inputs, acc held at +1 when shaping.
    step(5'd4, 5'd4, 1'b1);  chk("even_c4x4", 5'd2, 5'd2, 5'd0);
    step(5'd2, 5'd9, 1'b0);  chk("clip_c2x9", 5'd2, 5'd2, 5'd0);
    step(5'd1, 5'd10, 1'b1); chk("clip_c1x10", 5'd1, 5'd1, 5'd0);
    step(5'd3, 5'd12, 1'b0); chk("clip_c3x12", 5'd3, 5'd3, 5'd0);

    // Zero cases.
    step(5'd3, 5'd0, 1'b1); chk("zero_x_pn1", 5'd0, 5'd0, 5'd0);
    step(5'd3, 5'd0, 1'b0); chk("zero_x_pn0", 5'd0, 5'd0, 5'd0);
    step(5'd0, 5'd7, 1'b1); chk("zero_cap", 5'd0, 5'd0, 5'd0);
    step(5'd0, 5'd0, 1'b0); chk("all_zero", 5'd0, 5'd0, 5'd0);

    // acc must still be +1 here: shaping forces s=-1 against pn=1.
    step(5'd1, 5'd1, 1'b1);
`ifdef SWB_NOISE_SHAPE_EN
    chk("acc_held_x1", 5'd0, 5'd1, NEG1);
`else
    chk("acc_held_x1", 5'd1, 5'd0, 5'd1);
`endif

    // Shaping sequence with x=1, starting from acc=0.
    run_sum = 0;
    for (int i = 0; i < 8; i++) begin
      step(5'd2, 5'd1, pn_pat[i]);
      chk($sformatf("seq%0d", i), s_pos_exp[i] ? 5'd1 : 5'd0, s_pos_exp[i] ? 5'd0 : 5'd1,
          s_pos_exp[i] ? 5'd1 : NEG1);
      cmp($sformatf("seq%0d.sum", i), x_out1_o + x_out2_o, 5'd1);
      run_sum += (s_out_o == 5'd1) ? 1 : -1;
`ifdef SWB_NOISE_SHAPE_EN
      checks++;
      assert (run_sum >= -1 && run_sum <= 1)
      else begin
        errors++;
        $error("FAIL seq%0d.runsum observed=%0d expected=-1..1", i, run_sum);
      end
`endif
    end

    // Mid-stream asynchronous reset.
    step(5'd3, 5'd3, 1'b1); chk("pre_reset", 5'd2, 5'd1, 5'd1);
    #2 reset_i = 1'b0;
    #1 chk("mid_reset_async", 5'd0, 5'd0, 5'd0);
    @(posedge clk_i);
    #1 reset_i = 1'b1;
    step(5'd3, 5'd3, 1'b0); chk("post_reset_pn0", 5'd1, 5'd2, NEG1);

    // Odd x_eff = 2C-1: the larger child equals C.
    step(5'd4, 5'd7, 1'b0);
`ifdef SWB_NOISE_SHAPE_EN
    chk("odd_2c_minus1", 5'd4, 5'd3, 5'd1);
`else
    chk("odd_2c_minus1", 5'd3, 5'd4, NEG1);
`endif
    step(5'd15, 5'd31, 1'b1); chk("clip_max", 5'd15, 5'd15, 5'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
